// File: rtl/ipm_add_arbiter_pkg.sv
// ============================================================================
// ipm_add_arbiter_pkg : shared IPM width helper and result-register states
// Rev 1.0
// ============================================================================
`default_nettype none

package ipm_add_arbiter_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

    function automatic int unsigned ipm_data_w(input int unsigned v);
        return v * BYTE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ipm_add_arbiter_add.sv
// ============================================================================
// ipm_add_arbiter_add : IPM masked addition primitive (t = r ^ q)
// Rev 1.0
// ============================================================================
`default_nettype none

module ipm_add_arbiter_add #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] q,
    output logic [W-1:0] t
);

    assign t = r ^ q;

endmodule

`default_nettype wire

// File: rtl/ipm_add_arbiter.sv
// ============================================================================
// ipm_add_arbiter : two-requester round-robin front end sharing one IPM adder
// Rev 1.0
// ============================================================================
`default_nettype none

module ipm_add_arbiter
    import ipm_add_arbiter_pkg::*;
#(
    parameter int unsigned V = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic                      req1_valid,
    output logic                      req0_ready,
    output logic                      req1_ready,
    input  logic [ipm_data_w(V)-1:0]  req0_r,
    input  logic [ipm_data_w(V)-1:0]  req0_q,
    input  logic [ipm_data_w(V)-1:0]  req1_r,
    input  logic [ipm_data_w(V)-1:0]  req1_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ipm_data_w(V)-1:0]  out_t,
    output logic                      out_id
);

    localparam int unsigned DW = ipm_data_w(V);

    res_state_e      state_q, state_d;
    logic            prio_q, prio_d;
    logic [DW-1:0]   out_t_q, out_t_d;
    logic            out_id_q, out_id_d;

    logic            can_accept;
    logic            grant0, grant1;
    logic [DW-1:0]   mux_r, mux_q, sum_t;

    // rst_n gates the grants so nothing is accepted while reset is held.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || out_ready;
        grant0     = rst_n && can_accept && req0_valid && (!req1_valid || !prio_q);
        grant1     = rst_n && can_accept && req1_valid && (!req0_valid ||  prio_q);
    end

    assign mux_r = grant1 ? req1_r : req0_r;
    assign mux_q = grant1 ? req1_q : req0_q;

    ipm_add_arbiter_add #(
        .W (DW)
    ) u_add (
        .r (mux_r),
        .q (mux_q),
        .t (sum_t)
    );

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        out_t_d  = out_t_q;
        out_id_d = out_id_q;
        if (grant0 || grant1) begin
            state_d  = ST_FULL;
            out_t_d  = sum_t;
            out_id_d = grant1;
            prio_d   = !grant1;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d  = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            prio_q   <= 1'b0;
            out_t_q  <= '0;
            out_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            out_t_q  <= out_t_d;
            out_id_q <= out_id_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = (state_q == ST_FULL);
    assign out_t      = out_t_q;
    assign out_id     = out_id_q;

endmodule

`default_nettype wire

// File: tb/tb_ipm_add_arbiter.sv
// ============================================================================
// tb_ipm_add_arbiter : directed self-checking bench for ipm_add_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ipm_add_arbiter;

    localparam logic [63:0] R0   = 64'h00FF_00FF_00FF_00FF;
    localparam logic [63:0] Q0   = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] T0   = 64'h0FF0_0FF0_0FF0_0FF0;
    localparam logic [63:0] R1   = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] Q1   = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] T1   = 64'hEDCB_5678_6543_DEF0;
    localparam logic [63:0] R1B  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] Q1B  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] T1B  = 64'h1111_1111_EEEE_EEEE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_r, req0_q, req1_r, req1_q;
    logic        out_valid, out_ready, out_id;
    logic [63:0] out_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ipm_add_arbiter #(.V(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_r     (req0_r),
        .req0_q     (req0_q),
        .req1_r     (req1_r),
        .req1_q     (req1_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_t      (out_t),
        .out_id     (out_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_r = R0; req0_q = Q0; req1_r = R1; req1_q = Q1;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_t", out_t, 64'd0);
        chk("rst_out_id", {63'd0, out_id}, 64'd0);
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        edge_settle();
        edge_settle();
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Single request from requester 0
        edge_settle();
        req0_valid = 1'b1;
        #1;
        chk("single_ready0", {63'd0, req0_ready}, 64'd1);
        chk("single_ready1", {63'd0, req1_ready}, 64'd0);
        edge_settle();
        req0_valid = 1'b0;
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_t", out_t, T0);
        chk("single_id", {63'd0, out_id}, 64'd0);

        // Drain with no requests
        edge_settle();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_t_kept", out_t, T0);

        // Fresh reset so the priority pointer starts at requester 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("cont_ready1", {63'd0, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
            edge_settle();
            chk("cont_valid", {63'd0, out_valid}, 64'd1);
            chk("cont_id", {63'd0, out_id}, (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("cont_t", out_t, (i % 2 == 1) ? T1 : T0);
        end

        // Backpressure: result from requester 1 held, req1 waits
        out_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b1;
        req1_r = R1B; req1_q = Q1B;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready1", {63'd0, req1_ready}, 64'd0);
            chk("bp_ready0", {63'd0, req0_ready}, 64'd0);
            edge_settle();
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_t", out_t, T1);
            chk("bp_id", {63'd0, out_id}, 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready1", {63'd0, req1_ready}, 64'd1);
        edge_settle();
        chk("bp_new_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_new_t", out_t, T1B);
        chk("bp_new_id", {63'd0, out_id}, 64'd1);

        // Reset while FULL and stalled; both requesters pending
        out_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_t", out_t, 64'd0);
        chk("mid_rst_id", {63'd0, out_id}, 64'd0);
        chk("mid_rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("mid_rst_ready1", {63'd0, req1_ready}, 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", {63'd0, req0_ready}, 64'd1);
        chk("post_rst_ready1", {63'd0, req1_ready}, 64'd0);
        edge_settle();
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_id", {63'd0, out_id}, 64'd0);
        chk("post_rst_t", out_t, T0);

        req0_valid = 1'b0; req1_valid = 1'b0;
        edge_settle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
